// File: rtl/gpioemu_pkg.sv
// Shared definitions for the GPIO multiply/popcount emulator:
// FSM states, register map and STATUS bit positions.
package gpioemu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULT  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] ADDR_A1   = 16'h037F;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_WH   = 16'h0394;
  localparam logic [15:0] ADDR_L    = 16'h0398;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;

  localparam int STS_VALID = 0;
  localparam int STS_READY = 1;
  localparam int STS_DONE  = 2;
  localparam int STS_ERR   = 3;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 0; i < 64; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/gpioemu_mulpop_seq_mult.sv
// Shift-add multiplier: one multiplier bit per clock, full-width accumulator.
// done_p is high during the final step so the sequencer can advance on that edge.
module seq_mult_u #(
  parameter int OP_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OP_W-1:0]     a,
  input  logic [OP_W-1:0]     b,
  output logic                busy,
  output logic                done_p,
  output logic [2*OP_W-1:0]   product
);

  localparam int RES_W = 2 * OP_W;
  localparam int CW    = (OP_W > 1) ? $clog2(OP_W) : 1;

  logic [RES_W-1:0] acc_q;
  logic [RES_W-1:0] a_sh_q;
  logic [OP_W-1:0]  b_sh_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  assign done_p  = busy_q && (cnt_q == CW'(OP_W - 1));
  assign busy    = busy_q;
  assign product = acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      acc_q  <= '0;
      a_sh_q <= RES_W'(a);
      b_sh_q <= b;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (b_sh_q[0]) begin
        acc_q <= acc_q + a_sh_q;
      end
      a_sh_q <= a_sh_q << 1;
      b_sh_q <= b_sh_q >> 1;
      cnt_q  <= cnt_q + CW'(1);
      if (done_p) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gpioemu_mulpop.sv
// Bus-mapped multiply/popcount emulator: register decode, operation sequencing,
// status, completed-operation counter and gpio_in snapshot.
module gpioemu_mulpop
  import gpioemu_pkg::*;
#(
  parameter int OP_W  = 24,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);

  localparam int RES_W = 2 * OP_W;

  state_e            state_q;
  logic              srd_q, swr_q;
  logic [OP_W-1:0]   a1_q, a2_q;
  logic              valid_q, ready_q, done_q, err_q;
  logic [6:0]        l_q;
  logic [CNT_W-1:0]  op_count_q;
  logic [31:0]       gpio_in_s_q;
  logic [RES_W-1:0]  product;
  logic [63:0]       prod_ext;
  logic              mult_busy, mult_done_p;
  logic              rd_p, wr_p, ctrl_wr, start_s;
  logic [31:0]       status_s, rdata_d;
  logic              unused_ok;

  assign rd_p     = srd & ~srd_q;
  assign wr_p     = swr & ~swr_q;
  assign ctrl_wr  = wr_p && (saddress == ADDR_CTRL);
  assign start_s  = ctrl_wr && (state_q == ST_IDLE);
  assign prod_ext = 64'(product);

  assign gpio_out       = 32'(op_count_q);
  assign gpio_in_s_insp = gpio_in_s_q;
  assign unused_ok      = ^{sdata_in, mult_busy};

  seq_mult_u #(.OP_W(OP_W)) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (start_s),
    .a       (a1_q),
    .b       (a2_q),
    .busy    (mult_busy),
    .done_p  (mult_done_p),
    .product (product)
  );

  always_comb begin
    status_s = 32'h0;
    status_s[STS_VALID] = valid_q;
    status_s[STS_READY] = ready_q;
    status_s[STS_DONE]  = done_q;
    status_s[STS_ERR]   = err_q;
  end

  // Result registers read as zero until an operation has completed.
  always_comb begin
    rdata_d = 32'h0;
    case (saddress)
      ADDR_W:    rdata_d = done_q ? prod_ext[31:0]  : 32'h0;
      ADDR_WH:   rdata_d = done_q ? prod_ext[63:32] : 32'h0;
      ADDR_L:    rdata_d = done_q ? 32'(l_q)        : 32'h0;
      ADDR_CTRL: rdata_d = status_s;
      default:   rdata_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      srd_q       <= 1'b0;
      swr_q       <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      sdata_out   <= 32'h0;
      gpio_in_s_q <= 32'h0;
    end else begin
      srd_q <= srd;
      swr_q <= swr;
      if (wr_p && (saddress == ADDR_A1)) a1_q <= sdata_in[OP_W-1:0];
      if (wr_p && (saddress == ADDR_A2)) a2_q <= sdata_in[OP_W-1:0];
      if (rd_p) sdata_out <= rdata_d;
      if (gpio_latch) gpio_in_s_q <= gpio_in;
    end
  end

  // A start outside IDLE never disturbs the running operation; it only flags ERR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      l_q        <= 7'd0;
      op_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_q <= ST_MULT;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            l_q     <= 7'd0;
          end
        end
        ST_MULT: begin
          if (ctrl_wr) err_q <= 1'b1;
          if (mult_done_p) state_q <= ST_COUNT;
        end
        ST_COUNT: begin
          if (ctrl_wr) err_q <= 1'b1;
          l_q     <= popcount64(prod_ext);
          valid_q <= (prod_ext[63:32] == 32'h0);
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (ctrl_wr) err_q <= 1'b1;
          done_q     <= 1'b1;
          ready_q    <= 1'b1;
          op_count_q <= op_count_q + CNT_W'(1);
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpioemu_mulpop.sv
// Self-checking bench for gpioemu_mulpop: random and directed operations
// compared against a plain-arithmetic model of the peripheral.
module tb_gpioemu_mulpop;

  localparam int OP_W = 24;
  localparam logic [31:0] MASK = 32'h00FFFFFF;
  localparam logic [15:0] A_A1 = 16'h037F, A_A2 = 16'h0388, A_W = 16'h0390,
                          A_WH = 16'h0394, A_L = 16'h0398, A_CTRL = 16'h03A0;

  logic clk, reset, srd, swr, gpio_latch;
  logic [15:0] saddress;
  logic [31:0] sdata_in, sdata_out, gpio_in, gpio_out, gpio_in_s_insp;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  logic [31:0] m_a1, m_a2;

  gpioemu_mulpop dut (
    .clk(clk), .reset(reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_out(gpio_out), .gpio_in_s_insp(gpio_in_s_insp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int popcnt(input longint unsigned v);
    int c = 0;
    for (int i = 0; i < 64; i++) c += int'((v >> i) & 64'd1);
    return c;
  endfunction

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    saddress = addr; sdata_in = data; swr = 1'b1;
    @(negedge clk);
    swr = 1'b0;
    if (addr == A_A1) m_a1 = data & MASK;
    if (addr == A_A2) m_a2 = data & MASK;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
    @(negedge clk);
    saddress = addr; srd = 1'b1;
    @(negedge clk);
    srd = 1'b0;
    data = sdata_out;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    bus_write(A_A1, a);
    bus_write(A_A2, b);
    bus_write(A_CTRL, 32'h1);
    repeat (OP_W + 6) @(negedge clk);
    exp_cnt++;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    reset = 1'b1; srd = 1'b0; swr = 1'b0; saddress = 16'h0; sdata_in = 32'h0;
    gpio_in = 32'h0; gpio_latch = 1'b0; m_a1 = 32'h0; m_a2 = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus_read(A_CTRL, rd);
    total++; if (rd !== 32'h3) begin bad++; $display("FAIL reset_status got=%h exp=%h", rd, 32'h3); end
    bus_read(A_W, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_W got=%h exp=0", rd); end
    bus_read(A_L, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_L got=%h exp=0", rd); end
    total++; if (gpio_out !== 32'h0) begin bad++; $display("FAIL reset_gpio_out got=%h exp=0", gpio_out); end
    total++; if (gpio_in_s_insp !== 32'h0) begin bad++; $display("FAIL reset_snapshot got=%h exp=0", gpio_in_s_insp); end
  endtask

  task automatic test_mul_basic;
    logic [31:0] rd;
    bus_write(A_A1, 32'd3);
    bus_write(A_A2, 32'd5);
    bus_write(A_CTRL, 32'h1);
    // start took effect on the edge just passed; completion lands OP_W+2 edges later
    repeat (OP_W + 1) @(negedge clk);
    total++; if (gpio_out !== 32'd0) begin bad++; $display("FAIL latency_early got=%h exp=0", gpio_out); end
    @(negedge clk);
    exp_cnt++;
    total++; if (gpio_out !== 32'(exp_cnt)) begin bad++; $display("FAIL latency_done got=%h exp=%h", gpio_out, exp_cnt); end
    bus_read(A_W, rd);
    total++; if (rd !== 32'hF) begin bad++; $display("FAIL basic_W got=%h exp=f", rd); end
    bus_read(A_WH, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL basic_WH got=%h exp=0", rd); end
    bus_read(A_L, rd);
    total++; if (rd !== 32'd4) begin bad++; $display("FAIL basic_L got=%h exp=4", rd); end
    bus_read(A_CTRL, rd);
    total++; if (rd !== 32'h7) begin bad++; $display("FAIL basic_status got=%h exp=7", rd); end
  endtask

  task automatic test_mul_max;
    logic [31:0] rd;
    run_op(32'hFFFFFF, 32'hFFFFFF);
    bus_read(A_W, rd);
    total++; if (rd !== 32'hFE000001) begin bad++; $display("FAIL max_W got=%h exp=fe000001", rd); end
    bus_read(A_WH, rd);
    total++; if (rd !== 32'h0000FFFF) begin bad++; $display("FAIL max_WH got=%h exp=0000ffff", rd); end
    bus_read(A_L, rd);
    total++; if (rd !== 32'd24) begin bad++; $display("FAIL max_L got=%0d exp=24", rd); end
    bus_read(A_CTRL, rd);
    total++; if (rd !== 32'h6) begin bad++; $display("FAIL max_status got=%h exp=6", rd); end
    run_op(32'hAB000001, 32'hFFFFFF);
    bus_read(A_W, rd);
    total++; if (rd !== 32'h00FFFFFF) begin bad++; $display("FAIL a1_upper_ignored got=%h exp=00ffffff", rd); end
    total++; if (gpio_out !== 32'(exp_cnt)) begin bad++; $display("FAIL max_count got=%h exp=%h", gpio_out, exp_cnt); end
  endtask

  task automatic test_random;
    logic [31:0] rd, ra, rb;
    longint unsigned p;
    for (int it = 0; it < 8; it++) begin
      ra = (it % 2 == 0) ? $urandom : $urandom_range(0, 65535);
      rb = (it % 2 == 0) ? $urandom : $urandom_range(0, 65535);
      run_op(ra, rb);
      p = longint'(ra & MASK) * longint'(rb & MASK);
      bus_read(A_W, rd);
      total++; if (rd !== p[31:0]) begin bad++; $display("FAIL rand_W[%0d] got=%h exp=%h", it, rd, p[31:0]); end
      bus_read(A_WH, rd);
      total++; if (rd !== p[63:32]) begin bad++; $display("FAIL rand_WH[%0d] got=%h exp=%h", it, rd, p[63:32]); end
      bus_read(A_L, rd);
      total++; if (rd !== 32'(popcnt(p))) begin bad++; $display("FAIL rand_L[%0d] got=%0d exp=%0d", it, rd, popcnt(p)); end
      bus_read(A_CTRL, rd);
      total++; if (rd !== (32'h6 | ((p >> 32) == 0 ? 32'h1 : 32'h0))) begin bad++; $display("FAIL rand_status[%0d] got=%h", it, rd); end
      total++; if (gpio_out !== 32'(exp_cnt)) begin bad++; $display("FAIL rand_count[%0d] got=%h exp=%h", it, gpio_out, exp_cnt); end
    end
  endtask

  task automatic test_err_start;
    logic [31:0] rd, xa, xb, za;
    longint unsigned p1, p2;
    xa = $urandom_range(1, 4095); xb = $urandom_range(1, 4095); za = $urandom_range(1, 4095);
    p1 = longint'(xa) * longint'(xb);
    p2 = longint'(za) * longint'(xb);
    bus_write(A_A1, xa);
    bus_write(A_A2, xb);
    bus_write(A_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_A1, za);
    repeat (OP_W + 6) @(negedge clk);
    exp_cnt++;
    total++; if (gpio_out !== 32'(exp_cnt)) begin bad++; $display("FAIL err_count got=%h exp=%h", gpio_out, exp_cnt); end
    bus_read(A_CTRL, rd);
    total++; if (rd !== 32'hF) begin bad++; $display("FAIL err_status got=%h exp=f", rd); end
    bus_read(A_W, rd);
    total++; if (rd !== p1[31:0]) begin bad++; $display("FAIL err_first_result got=%h exp=%h", rd, p1[31:0]); end
    bus_write(A_CTRL, 32'h1);
    repeat (OP_W + 6) @(negedge clk);
    exp_cnt++;
    bus_read(A_CTRL, rd);
    total++; if (rd !== 32'h7) begin bad++; $display("FAIL err_cleared got=%h exp=7", rd); end
    bus_read(A_W, rd);
    total++; if (rd !== p2[31:0]) begin bad++; $display("FAIL busy_write_A1 got=%h exp=%h", rd, p2[31:0]); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    bus_write(A_A1, 32'h1234);
    bus_write(A_A2, 32'h55);
    bus_write(A_CTRL, 32'h1);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0; m_a1 = 32'h0; m_a2 = 32'h0;
    total++; if (gpio_out !== 32'h0) begin bad++; $display("FAIL midreset_count got=%h exp=0", gpio_out); end
    bus_read(A_CTRL, rd);
    total++; if (rd !== 32'h3) begin bad++; $display("FAIL midreset_status got=%h exp=3", rd); end
    bus_read(A_W, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL midreset_W got=%h exp=0", rd); end
    repeat (OP_W + 6) @(negedge clk);
    total++; if (gpio_out !== 32'h0) begin bad++; $display("FAIL midreset_no_incr got=%h exp=0", gpio_out); end
  endtask

  task automatic test_dual_strobe;
    logic [31:0] rd;
    @(negedge clk);
    saddress = A_CTRL; srd = 1'b1; swr = 1'b1;
    @(negedge clk);
    srd = 1'b0; swr = 1'b0;
    total++; if (sdata_out !== 32'h3) begin bad++; $display("FAIL dual_read got=%h exp=3", sdata_out); end
    bus_read(A_CTRL, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL dual_start got=%h exp=1", rd); end
    repeat (OP_W + 6) @(negedge clk);
    exp_cnt++;
    bus_read(A_CTRL, rd);
    total++; if (rd !== 32'h7) begin bad++; $display("FAIL zero_op_status got=%h exp=7", rd); end
    bus_read(A_W, rd);
    total++; if (rd !== (m_a1 * m_a2)) begin bad++; $display("FAIL zero_op_W got=%h exp=%h", rd, m_a1 * m_a2); end
    total++; if (gpio_out !== 32'(exp_cnt)) begin bad++; $display("FAIL dual_count got=%h exp=%h", gpio_out, exp_cnt); end
    bus_read(16'h0500, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmapped got=%h exp=0", rd); end
    bus_read(A_A1, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL write_only_read got=%h exp=0", rd); end
  endtask

  task automatic test_gpio_latch;
    @(negedge clk);
    gpio_in = 32'hDEADBEEF; gpio_latch = 1'b1;
    @(negedge clk);
    gpio_latch = 1'b0; gpio_in = 32'h12345678;
    repeat (2) @(negedge clk);
    total++; if (gpio_in_s_insp !== 32'hDEADBEEF) begin bad++; $display("FAIL gpio_snapshot got=%h exp=deadbeef", gpio_in_s_insp); end
    gpio_latch = 1'b1;
    @(negedge clk);
    gpio_latch = 1'b0;
    total++; if (gpio_in_s_insp !== 32'h12345678) begin bad++; $display("FAIL gpio_relatch got=%h exp=12345678", gpio_in_s_insp); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_max();
    test_random();
    test_err_start();
    test_reset_mid();
    test_dual_strobe();
    test_gpio_latch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
